// File: rtl/intr_pkg.sv
// Shared types and bit-vector helpers for the priority interrupt controller.
package intr_pkg;

  localparam int NIRQ_DEF = 8;

  typedef logic [NIRQ_DEF-1:0] irq_vec_t;

  // Bit 0 is highest priority, so the lowest set bit is the winner.
  function automatic irq_vec_t lowest_one_hot(input irq_vec_t v);
    return v & (~v + irq_vec_t'(1));
  endfunction

  function automatic logic is_one_hot(input irq_vec_t v);
    return (v != '0) && ((v & (v - irq_vec_t'(1))) == '0);
  endfunction

endpackage

// File: rtl/irq_sync.sv
// Multi-stage synchroniser for a bus of asynchronous interrupt lines,
// followed by a previous-value flop for rising-edge detection.
module irq_sync #(
  parameter int NIRQ        = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NIRQ-1:0] irq,
  output logic [NIRQ-1:0] irq_edge
);

  logic [SYNC_STAGES-1:0][NIRQ-1:0] sync_q;
  logic [NIRQ-1:0]                  prev_q;

  // NOTE: every stage is reset so a line held high across reset release is
  // seen as a fresh rising edge rather than an unknown value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      // NOTE: non-blocking assignments make each stage take the old value of
      // the one before it, which is what makes this a shift chain.
      sync_q <= {sync_q[SYNC_STAGES-2:0], irq};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign irq_edge = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/intr_ctrl.sv
// Priority interrupt controller: pending/overrun/mask/in-service registers and
// the one-hot request/active encoders consumed by the control unit.
module intr_ctrl
  import intr_pkg::*;
#(
  parameter int NIRQ        = NIRQ_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NIRQ-1:0] irq,
  input  logic            mask_we,
  input  logic [NIRQ-1:0] mask_data,
  input  logic            ovr_clr,
  input  logic [NIRQ-1:0] call_ack,
  input  logic [NIRQ-1:0] ret_ack,
  output logic [NIRQ-1:0] min_bit_s,
  output logic [NIRQ-1:0] min_bit_a,
  output logic [NIRQ-1:0] pending,
  output logic [NIRQ-1:0] mask,
  output logic [NIRQ-1:0] ovr
);

  logic [NIRQ-1:0] irq_edge;
  logic [NIRQ-1:0] in_service;
  logic [NIRQ-1:0] pend_masked;
  logic [NIRQ-1:0] call_clr;

  irq_sync #(
    .NIRQ        (NIRQ),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_irq_sync (
    .clk      (clk),
    .reset    (reset),
    .irq      (irq),
    .irq_edge (irq_edge)
  );

  assign pend_masked = pending & mask;

  // A call is honoured only for a single line that is actually requesting.
  always_comb begin
    // NOTE: default first so no path leaves call_clr unassigned (no latch).
    call_clr = '0;
    if (is_one_hot(call_ack) && ((call_ack & pend_masked) != '0))
      call_clr = call_ack;
  end

  // A new edge always wins over a clear, so a request arriving during its own
  // call is kept for a later re-entry rather than being flagged as overrun.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending    <= '0;
      ovr        <= '0;
      mask       <= '0;
      in_service <= '0;
    end else begin
      pending    <= irq_edge | (pending & ~call_clr);
      ovr        <= (ovr & ~{NIRQ{ovr_clr}}) | (irq_edge & pending & ~call_clr);
      in_service <= (in_service & ~ret_ack) | call_clr;
      if (mask_we)
        mask <= mask_data;
    end
  end

  assign min_bit_s = lowest_one_hot(pend_masked);
  assign min_bit_a = lowest_one_hot(in_service);

endmodule

// File: tb/tb_intr_ctrl.sv
// Scoreboard bench for intr_ctrl: a per-line reference model predicts every
// cycle's outputs, a monitor compares them; directed scenarios then random traffic.
module tb_intr_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] irq, mask_data, call_ack, ret_ack;
  logic       mask_we, ovr_clr;
  logic [7:0] min_bit_s, min_bit_a, pending, mask, ovr;

  intr_ctrl #(.NIRQ(8), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .irq       (irq),
    .mask_we   (mask_we),
    .mask_data (mask_data),
    .ovr_clr   (ovr_clr),
    .call_ack  (call_ack),
    .ret_ack   (ret_ack),
    .min_bit_s (min_bit_s),
    .min_bit_a (min_bit_a),
    .pending   (pending),
    .mask      (mask),
    .ovr       (ovr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [7:0] s, a, pend, msk, ov;
  } exp_t;
  exp_t exp_q[$];

  // Per-line state; samples[] holds irq as seen at the last three clock edges.
  bit m_pend[8], m_ins[8], m_ovr[8], m_mask[8];
  bit samp1[8], samp2[8], samp3[8];

  function automatic logic [7:0] pack(input bit v[8]);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[i];
    return r;
  endfunction

  // Highest-priority (lowest index) line of a vector, as a one-hot value.
  function automatic logic [7:0] winner(input logic [7:0] v);
    for (int i = 0; i < 8; i++)
      if (v[i]) return 8'h01 << i;
    return 8'h00;
  endfunction

  function automatic int ones(input logic [7:0] v);
    int n = 0;
    for (int i = 0; i < 8; i++) n += int'(v[i]);
    return n;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 8; i++) begin
        m_pend[i] = 0; m_ins[i] = 0; m_ovr[i] = 0; m_mask[i] = 0;
        samp1[i] = 0; samp2[i] = 0; samp3[i] = 0;
      end
      exp_q.delete();
    end else begin
      int  taken;
      bit  request;
      exp_t e;
      // A call enters a line only if exactly one line is named and it is pending and enabled.
      taken = -1;
      if (ones(call_ack) == 1)
        for (int i = 0; i < 8; i++)
          if (call_ack[i] && m_pend[i] && m_mask[i]) taken = i;
      for (int i = 0; i < 8; i++) begin
        // A request reaches the registers two edges after irq is first seen high.
        request = samp2[i] && !samp3[i];
        if (ovr_clr) m_ovr[i] = 0;
        if (request) begin
          if (m_pend[i] && taken != i) m_ovr[i] = 1;
          m_pend[i] = 1;
        end else if (taken == i) begin
          m_pend[i] = 0;
        end
        if (ret_ack[i]) m_ins[i] = 0;
        if (taken == i) m_ins[i] = 1;
        if (mask_we) m_mask[i] = mask_data[i];
        samp3[i] = samp2[i];
        samp2[i] = samp1[i];
        samp1[i] = irq[i];
      end
      e.pend = pack(m_pend);
      e.msk  = pack(m_mask);
      e.ov   = pack(m_ovr);
      e.s    = winner(e.pend & e.msk);
      e.a    = winner(pack(m_ins));
      exp_q.push_back(e);
    end
  end

  // ---------------- monitor ----------------
  always @(posedge clk) begin
    #1;
    if (reset === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_empty: got no expected entry at %0t", $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sb_min_bit_s", min_bit_s, e.s);
        check("sb_min_bit_a", min_bit_a, e.a);
        check("sb_pending",   pending,   e.pend);
        check("sb_mask",      mask,      e.msk);
        check("sb_ovr",       ovr,       e.ov);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive_idle();
    mask_we  = 1'b0;
    ovr_clr  = 1'b0;
    call_ack = 8'h00;
    ret_ack  = 8'h00;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      drive_idle();
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_min_bit_s"}, min_bit_s, 8'h00);
    check({tag, "_min_bit_a"}, min_bit_a, 8'h00);
    check({tag, "_pending"},   pending,   8'h00);
    check({tag, "_mask"},      mask,      8'h00);
    check({tag, "_ovr"},       ovr,       8'h00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  logic [7:0] oh;

  initial begin
    reset     = 1'b0;
    irq       = 8'h00;
    mask_data = 8'h00;
    drive_idle();
    #2;
    check_all_zero("reset");
    @(negedge clk);
    reset = 1'b1;

    // Enable all lines, then raise irq[3] and watch the two-edge latency.
    mask_we = 1'b1; mask_data = 8'hFF;
    step(1);
    check("mask_ff", mask, 8'hFF);
    irq[3] = 1'b1;
    step(2);
    check("irq_lat_early", pending, 8'h00);
    step(1);
    check("irq3_pending", pending, 8'h08);
    check("irq3_min_s", min_bit_s, 8'h08);

    call_ack = 8'h08; step(1);
    check("call3_min_s", min_bit_s, 8'h00);
    check("call3_min_a", min_bit_a, 8'h08);

    // Nested entry of line 1 over line 3, then unwind.
    irq[1] = 1'b1; step(3);
    check("irq1_min_s", min_bit_s, 8'h02);
    call_ack = 8'h02; step(1);
    check("nest_min_a", min_bit_a, 8'h02);
    ret_ack = 8'h02; step(1);
    check("unwind1_min_a", min_bit_a, 8'h08);
    ret_ack = 8'h08; step(1);
    check("unwind3_min_a", min_bit_a, 8'h00);

    // A masked request stays pending and reappears once unmasked.
    mask_we = 1'b1; mask_data = 8'hFE; step(1);
    irq[0] = 1'b1; step(3);
    check("masked_pending", pending, 8'h01);
    check("masked_min_s", min_bit_s, 8'h00);
    mask_we = 1'b1; mask_data = 8'hFF; step(1);
    check("unmasked_min_s", min_bit_s, 8'h01);
    call_ack = 8'h01; step(1);
    ret_ack = 8'h01; step(1);

    // Overrun on a second edge while still pending, then clear it.
    irq[5] = 1'b1; step(3);
    check("irq5_pending", pending, 8'h20);
    irq[5] = 1'b0; step(3);
    irq[5] = 1'b1; step(3);
    check("ovr_set", ovr, 8'h20);
    ovr_clr = 1'b1; step(1);
    check("ovr_clr", ovr, 8'h00);

    // Edge coinciding with the call: pending survives, no overrun.
    irq[5] = 1'b0; step(3);
    irq[5] = 1'b1; step(2);
    call_ack = 8'h20; step(1);
    check("coincide_pending5", pending & 8'h20, 8'h20);
    check("coincide_min_a", min_bit_a, 8'h20);
    check("coincide_ovr", ovr, 8'h00);
    ret_ack = 8'h20; step(1);
    call_ack = 8'h20; step(1);
    ret_ack = 8'h20; step(1);

    // Multi-hot and not-pending calls are ignored.
    irq[3:0] = 4'h0; step(3);
    irq[3:2] = 2'b11; step(3);
    check("multi_pre_pending", pending, 8'h0C);
    call_ack = 8'h0C; step(1);
    check("multi_pending", pending, 8'h0C);
    check("multi_min_a", min_bit_a, 8'h00);
    call_ack = 8'h10; step(1);
    check("notpend_min_a", min_bit_a, 8'h00);

    // Nest lines 2 and 3, then reset asynchronously mid-cycle.
    call_ack = 8'h04; step(1);
    call_ack = 8'h08; step(1);
    check("nest23_min_a", min_bit_a, 8'h04);
    @(posedge clk);
    #3;
    reset = 1'b0;
    irq   = 8'h00;
    #1;
    check_all_zero("async_reset");
    step(2);
    reset = 1'b1;

    // Randomised traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < 8; b++)
        if ($urandom_range(7) == 0) irq[b] = ~irq[b];
      mask_we   = ($urandom_range(15) == 0);
      mask_data = 8'($urandom) | 8'($urandom);
      ovr_clr   = ($urandom_range(31) == 0);
      oh        = 8'h01 << $urandom_range(7);
      case ($urandom_range(3))
        0:       call_ack = winner(pack(m_pend) & pack(m_mask));
        1:       call_ack = oh;
        2:       call_ack = 8'($urandom);
        default: call_ack = 8'h00;
      endcase
      case ($urandom_range(2))
        0:       ret_ack = winner(pack(m_ins));
        1:       ret_ack = 8'h01 << $urandom_range(7);
        default: ret_ack = 8'h00;
      endcase
      @(negedge clk);
    end
    drive_idle();
    step(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
